// File: rtl/controlador_hd.sv
// controlador_hd: multi-cycle sequencer for the HD syscalls HD_TO_REG / REG_TO_HD.
// It freezes the single-cycle core while a disk access is in flight. It issues one
// command strobe to the HD, then waits for hd_ready under a timeout. It retires the
// access with a one-cycle done pulse, and the read data is kept for the writeback path.
module controlador_hd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int HD_DEPTH = 4096,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              hd_err,
    output logic              hd_en,
    output logic              hd_we,
    output logic [ADDR_W-1:0] hd_addr,
    output logic [DATA_W-1:0] hd_wdata,
    input  logic [DATA_W-1:0] hd_rdata,
    input  logic              hd_ready
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]   TOUT_LAST = TW'(TIMEOUT - 1);
    // One extra bit so that HD_DEPTH == 2**ADDR_W can be represented.
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(HD_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [TW-1:0]       timer_r;
    logic                err_r;
    logic                hd_we_r;
    logic [ADDR_W-1:0]   hd_addr_r;
    logic [DATA_W-1:0]   hd_wdata_r;
    logic [DATA_W-1:0]   rdata_r;

    logic                req_s;
    logic                range_err_s;
    logic                latch_s;
    logic                fin_s;
    logic                fin_err_s;
    logic [DATA_W-1:0]   fin_data_s;
    logic                timer_clr_s;
    logic                timer_inc_s;

    assign req_s       = req_rd | req_wr;
    assign range_err_s = ({1'b0, addr} >= DEPTH_L);

    assign hd_we    = hd_we_r;
    assign hd_addr  = hd_addr_r;
    assign hd_wdata = hd_wdata_r;
    assign rdata    = rdata_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode, core/HD control strobes and datapath load enables.
    always_comb begin
        state_nxt_s = state_r;
        stall       = 1'b0;
        done        = 1'b0;
        hd_err      = 1'b0;
        hd_en       = 1'b0;
        latch_s     = 1'b0;
        fin_s       = 1'b0;
        fin_err_s   = 1'b0;
        fin_data_s  = '0;
        timer_clr_s = 1'b0;
        timer_inc_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                stall = req_s;
                if (req_s) begin
                    latch_s = 1'b1;
                    if (range_err_s) begin
                        // Out-of-range address: abort without touching the HD.
                        fin_s       = 1'b1;
                        fin_err_s   = 1'b1;
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_CMD;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CMD: begin
                stall       = 1'b1;
                hd_en       = 1'b1;
                timer_clr_s = 1'b1;
                state_nxt_s = S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (hd_ready) begin
                    // A ready arriving on the timeout cycle still counts as success.
                    fin_s       = 1'b1;
                    fin_data_s  = hd_we_r ? {DATA_W{1'b0}} : hd_rdata;
                    state_nxt_s = S_DONE;
                end else if (timer_r == TOUT_LAST) begin
                    fin_s       = 1'b1;
                    fin_err_s   = 1'b1;
                    state_nxt_s = S_DONE;
                end else begin
                    timer_inc_s = 1'b1;
                    state_nxt_s = S_WAIT;
                end
            end
            S_DONE: begin
                // Request may still be high here; it is the retiring instruction.
                done        = 1'b1;
                hd_err      = err_r;
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Command latch, wait timer and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hd_we_r    <= 1'b0;
            hd_addr_r  <= '0;
            hd_wdata_r <= '0;
            timer_r    <= '0;
            rdata_r    <= '0;
            err_r      <= 1'b0;
        end else begin
            if (latch_s) begin
                hd_we_r    <= req_wr;   // write wins over a simultaneous read
                hd_addr_r  <= addr;
                hd_wdata_r <= wdata;
            end
            if (timer_clr_s) begin
                timer_r <= '0;
            end else if (timer_inc_s) begin
                timer_r <= timer_r + TW'(1);
            end
            if (fin_s) begin
                rdata_r <= fin_data_s;
                err_r   <= fin_err_s;
            end
        end
    end

endmodule

// File: tb/tb_controlador_hd.sv
// Directed bench for controlador_hd with a done-driven scoreboard.
module tb_controlador_hd;

    localparam int DW = 32;
    localparam int AW = 13;   // one spare bit so address 4096 can be presented
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_rd, req_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stall, done, hd_err, hd_en, hd_we;
    logic [DW-1:0] rdata, hd_wdata, hd_rdata;
    logic [AW-1:0] hd_addr;
    logic          hd_ready;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          e;
    } exp_t;
    exp_t sb_q[$];

    controlador_hd #(.DATA_W(DW), .ADDR_W(AW), .HD_DEPTH(4096), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .addr(addr),
        .wdata(wdata), .stall(stall), .done(done), .rdata(rdata), .hd_err(hd_err),
        .hd_en(hd_en), .hd_we(hd_we), .hd_addr(hd_addr), .hd_wdata(hd_wdata),
        .hd_rdata(hd_rdata), .hd_ready(hd_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 (rdata=0x%0h), expected no done", rdata);
            end else begin
                e = sb_q.pop_front();
                check("done_rdata", 64'(rdata), 64'(e.d));
                check("done_err", 64'(hd_err), 64'(e.e));
            end
        end
    end

    // One access: request held until done, HD answers dly cycles after hd_en
    // (dly<0: never). Afterwards post idle cycles with a stray hd_ready pulse.
    task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int dly, input logic [DW-1:0] hdd,
                          input logic [DW-1:0] er, input logic ee, input int exp_en,
                          input int exp_done, input int exp_stall, input logic exp_we,
                          input int post);
        int en_cnt = 0, stall_cnt = 0, en_cyc = -1, done_cyc = -1;
        logic          we_c = 1'b0;
        logic [AW-1:0] addr_c = '0;
        logic [DW-1:0] wd_c = '0;
        sb_q.push_back({er, ee});
        @(posedge clk); #1;
        req_rd = rd; req_wr = wr; addr = a; wdata = wd;
        for (int i = 0; i < 60 && done_cyc < 0; i++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (hd_en) begin
                en_cnt++; en_cyc = i; we_c = hd_we; addr_c = hd_addr; wd_c = hd_wdata;
            end
            if (done) done_cyc = i;
            @(posedge clk); #1;
            hd_ready = (dly >= 0 && en_cyc >= 0 && i + 1 == en_cyc + dly);
            hd_rdata = hdd;
            if (done_cyc >= 0) begin
                req_rd = 1'b0; req_wr = 1'b0;
            end
        end
        if (done_cyc < 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: got no done in 60 cycles, expected done at %0d", exp_done);
            req_rd = 1'b0; req_wr = 1'b0;
        end else begin
            check("done_latency", 64'(done_cyc), 64'(exp_done));
        end
        check("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
        if (exp_en > 0) begin
            check("cmd_we", 64'(we_c), 64'(exp_we));
            check("cmd_addr", 64'(addr_c), 64'(a));
            if (exp_we) check("cmd_wdata", 64'(wd_c), 64'(wd));
        end
        for (int j = 0; j < post; j++) begin
            @(negedge clk);
            if (hd_en) en_cnt++;
            check("rdata_hold", 64'(rdata), 64'(er));
            @(posedge clk); #1;
            hd_ready = (j == 0);
        end
        hd_ready = 1'b0;
        check("hd_en_count", 64'(en_cnt), 64'(exp_en));
    endtask

    initial begin
        rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; addr = '0; wdata = '0;
        hd_rdata = '0; hd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hd_en", 64'(hd_en), 64'd0);
        check("rst_hd_we", 64'(hd_we), 64'd0);
        check("rst_hd_err", 64'(hd_err), 64'd0);
        check("rst_hd_addr", 64'(hd_addr), 64'd0);
        check("rst_hd_wdata", 64'(hd_wdata), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);

        // Read addr 5, HD answers 2 cycles after hd_en: done at cycle 4, stall 4 cycles.
        access(1'b1, 1'b0, 13'd5, 32'h0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0,
               1, 4, 4, 1'b0, 3);

        // Reset during WAIT aborts silently.
        @(posedge clk); #1;
        req_rd = 1'b1; addr = 13'd9;
        @(negedge clk);
        check("r6_stall_req", 64'(stall), 64'd1);
        @(negedge clk);
        check("r6_hd_en_cmd", 64'(hd_en), 64'd1);
        @(negedge clk);
        check("r6_wait_hd_en", 64'(hd_en), 64'd0);
        rst = 1'b1; req_rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; hd_ready = 1'b1; hd_rdata = 32'h5555_AAAA;
        @(negedge clk);
        check("r6_stall_after", 64'(stall), 64'd0);
        check("r6_done_after", 64'(done), 64'd0);
        check("r6_hd_en_after", 64'(hd_en), 64'd0);
        check("r6_rdata_cleared", 64'(rdata), 64'd0);
        @(posedge clk); #1;
        hd_ready = 1'b0;
        repeat (4) @(negedge clk);

        // Write addr 7, ready 1 cycle after hd_en.
        access(1'b0, 1'b1, 13'd7, 32'h0000_1234, 1, 32'hFFFF_FFFF, 32'h0, 1'b0,
               1, 3, 3, 1'b1, 2);
        // Out-of-range read: no command, done next cycle with error.
        access(1'b1, 1'b0, 13'd4096, 32'h0, 1, 32'h1111_1111, 32'h0, 1'b1,
               0, 1, 1, 1'b0, 2);
        // Last valid address is accepted.
        access(1'b1, 1'b0, 13'd4095, 32'h0, 1, 32'hA5A5_0FF0, 32'hA5A5_0FF0, 1'b0,
               1, 3, 3, 1'b0, 2);
        // No ready: 16 WAIT cycles, done at cycle 18 with error; later ready ignored.
        access(1'b1, 1'b0, 13'd12, 32'h0, -1, 32'h2222_2222, 32'h0, 1'b1,
               1, 18, 18, 1'b0, 4);
        // Read and write together: write wins; request held through DONE.
        access(1'b1, 1'b1, 13'd3, 32'hCAFE_0003, 1, 32'h3333_3333, 32'h0, 1'b0,
               1, 3, 3, 1'b1, 4);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
